// File: rtl/uart_frame_tx.sv
// uart_frame_tx
// Serializes one command frame into a byte-level UART transmitter, one byte per
// send/done handshake. Frame layout: HDR0, HDR1, cmd, payload bytes 0..4, and
// when UART_FRAME_CHKSUM_EN is defined, a trailing checksum byte equal to
// (cmd + payload bytes 0..4) mod 256.
//
// Build option: `define UART_FRAME_CHKSUM_EN appends the checksum byte (9-byte
// frame); without it the frame is 8 bytes and no checksum logic exists.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous, active-high reset
//   i_send_go      one-cycle frame request, sampled only while idle
//   i_cmd          command byte (frame byte 2), latched on accept
//   i_payload      payload; i_payload[8*i+7:8*i] is frame byte 3+i
//   o_busy         high from the cycle after accept until the frame completes
//   o_frame_done   one-cycle pulse after the last byte's tx_done
//   o_tx_data      byte for the byte transmitter, held while outstanding
//   o_tx_send_go   one-cycle pulse starting one byte transmission
//   i_tx_done      one-cycle pulse from the byte transmitter
module uart_frame_tx #(
   parameter logic [7:0]  HDR0       = 8'h55,
   parameter logic [7:0]  HDR1       = 8'hA5,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_send_go,
   input  logic [7:0]  i_cmd,
   input  logic [39:0] i_payload,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_send_go,
   input  logic        i_tx_done
);

`ifdef UART_FRAME_CHKSUM_EN
   localparam logic [3:0] LastIdx = 4'd8;
`else
   localparam logic [3:0] LastIdx = 4'd7;
`endif
   localparam logic [7:0] GapLoad = 8'(GAP_CYCLES);

   typedef enum logic [1:0] {StIdle, StSend, StWait, StGap} state_e;

   state_e      r_state, w_state_d;
   logic [3:0]  r_idx, w_idx_d;
   logic [7:0]  r_gap, w_gap_d;
   logic [7:0]  r_cmd;
   logic [39:0] r_payload;
   logic [7:0]  r_tx_data;
   logic        r_frame_done, w_frame_done_d;
   logic        w_load;
   logic [7:0]  w_byte;

`ifdef UART_FRAME_CHKSUM_EN
   logic [7:0] w_chksum;
   assign w_chksum = r_cmd + r_payload[7:0] + r_payload[15:8] + r_payload[23:16]
                   + r_payload[31:24] + r_payload[39:32];
`endif

   // Byte for the index about to be sent. On accept the index is 0 (HDR0), so
   // the not-yet-latched frame registers are never selected in that cycle.
   always_comb begin
      w_byte = 8'h00;
      case (w_idx_d)
         4'd0:    w_byte = HDR0;
         4'd1:    w_byte = HDR1;
         4'd2:    w_byte = r_cmd;
         4'd3:    w_byte = r_payload[7:0];
         4'd4:    w_byte = r_payload[15:8];
         4'd5:    w_byte = r_payload[23:16];
         4'd6:    w_byte = r_payload[31:24];
         4'd7:    w_byte = r_payload[39:32];
`ifdef UART_FRAME_CHKSUM_EN
         4'd8:    w_byte = w_chksum;
`endif
         default: w_byte = 8'h00;
      endcase
   end

   always_comb begin
      w_state_d      = r_state;
      w_idx_d        = r_idx;
      w_gap_d        = r_gap;
      w_frame_done_d = 1'b0;
      w_load         = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_send_go) begin
               w_load    = 1'b1;
               w_idx_d   = 4'd0;
               w_state_d = StSend;
            end
         end
         StSend: begin
            w_state_d = StWait;
         end
         StWait: begin
            if (i_tx_done) begin
               if (r_idx == LastIdx) begin
                  w_frame_done_d = 1'b1;
                  w_idx_d        = 4'd0;
                  w_state_d      = StIdle;
               end else begin
                  w_idx_d = r_idx + 4'd1;
                  if (GAP_CYCLES > 0) begin
                     w_gap_d   = GapLoad;
                     w_state_d = StGap;
                  end else begin
                     w_state_d = StSend;
                  end
               end
            end
         end
         StGap: begin
            // Loaded with G, so G cycles are spent here before SEND.
            if (r_gap <= 8'd1) begin
               w_gap_d   = 8'd0;
               w_state_d = StSend;
            end else begin
               w_gap_d = r_gap - 8'd1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_idx        <= 4'd0;
         r_gap        <= 8'd0;
         r_cmd        <= 8'h00;
         r_payload    <= 40'h0;
         r_tx_data    <= 8'h00;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_idx        <= w_idx_d;
         r_gap        <= w_gap_d;
         r_frame_done <= w_frame_done_d;
         if (w_load) begin
            r_cmd     <= i_cmd;
            r_payload <= i_payload;
         end
         // Loaded on entry so the byte is valid throughout the SEND cycle.
         if (w_state_d == StSend) begin
            r_tx_data <= w_byte;
         end
      end
   end

   assign o_busy       = (r_state != StIdle);
   assign o_tx_send_go = (r_state == StSend);
   assign o_frame_done = r_frame_done;
   assign o_tx_data    = r_tx_data;

endmodule

// File: tb/tb_uart_frame_tx.sv
`timescale 1ns/1ps
module tb_uart_frame_tx;
`ifdef UART_FRAME_CHKSUM_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   typedef struct {
      logic [7:0]  cmd;
      logic [39:0] payload;
      logic [71:0] exp;   // frame byte 0 in the top byte; checksum in the lowest
   } vec_t;

   vec_t vec [5];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  cmd;
   logic [39:0] payload;
   logic        send_go0, send_go3;
   logic        busy0, fd0, sgo0, done0;
   logic        busy3, fd3, sgo3, done3;
   logic [7:0]  data0, data3;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int cnt0  = 0;
   int cnt3  = 0;
   int nfd0  = 0;
   int nfd3  = 0;
   int ldone0 = 0;
   int ldone3 = 0;
   logic [7:0] q0[$];
   logic [7:0] q3[$];

   uart_frame_tx #(.HDR0(8'h55), .HDR1(8'hA5), .GAP_CYCLES(0)) dut0 (
      .i_clk(clk), .i_reset(rst), .i_send_go(send_go0), .i_cmd(cmd), .i_payload(payload),
      .o_busy(busy0), .o_frame_done(fd0), .o_tx_data(data0), .o_tx_send_go(sgo0),
      .i_tx_done(done0)
   );

   uart_frame_tx #(.HDR0(8'h55), .HDR1(8'hA5), .GAP_CYCLES(3)) dut3 (
      .i_clk(clk), .i_reset(rst), .i_send_go(send_go3), .i_cmd(cmd), .i_payload(payload),
      .o_busy(busy3), .o_frame_done(fd3), .o_tx_data(data3), .o_tx_send_go(sgo3),
      .i_tx_done(done3)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Byte transmitter models: tx_done 10 cycles after tx_send_go, not reset.
   initial done0 = 1'b0;
   initial done3 = 1'b0;
   always @(posedge clk) begin
      done0 <= (cnt0 == 1);
      if (sgo0) cnt0 <= 10;
      else if (cnt0 > 0) cnt0 <= cnt0 - 1;
      done3 <= (cnt3 == 1);
      if (sgo3) cnt3 <= 10;
      else if (cnt3 > 0) cnt3 <= cnt3 - 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitors: capture sent bytes, check done-to-send spacing and busy at frame_done.
   initial forever begin
      @(negedge clk);
      if (sgo0) begin
         if (q0.size() > 0) chk("gap0", cyc - ldone0, 1);
         q0.push_back(data0);
      end
      if (done0) ldone0 = cyc;
      if (fd0) begin
         nfd0++;
         chk("busy_low_at_done0", busy0, 0);
      end
   end

   initial forever begin
      @(negedge clk);
      if (sgo3) begin
         if (q3.size() > 0) chk("gap3", cyc - ldone3, 4);
         q3.push_back(data3);
      end
      if (done3) ldone3 = cyc;
      if (fd3) begin
         nfd3++;
         chk("busy_low_at_done3", busy3, 0);
      end
   end

   function automatic logic [71:0] pack(input int sel);
      logic [71:0] v;
      logic [7:0]  b;
      v = '0;
      for (int k = 0; k < 9; k++) begin
         if (sel == 0) b = (k < q0.size()) ? q0[k] : 8'h00;
         else          b = (k < q3.size()) ? q3[k] : 8'h00;
         v[71-8*k -: 8] = b;
      end
      return v;
   endfunction

   task automatic cmp(input string nm, input int sel, input int vi);
      logic [71:0] g;
      logic [71:0] e;
      int n;
      n = (sel == 0) ? q0.size() : q3.size();
      g = pack(sel);
      e = vec[vi].exp;
      chk({nm, "_len"}, n, NB);
      for (int k = 0; k < NB; k++)
         chk($sformatf("%s_b%0d", nm, k), g[71-8*k -: 8], e[71-8*k -: 8]);
   endtask

   task automatic start0(input int vi);
      cmd     = vec[vi].cmd;
      payload = vec[vi].payload;
      q0.delete();
      @(posedge clk); #1 send_go0 = 1'b1;
      @(posedge clk); #1 send_go0 = 1'b0;
      chk("accept_busy0", busy0, 1);
      chk("accept_sgo0", sgo0, 1);
      chk("accept_hdr0", data0, 8'h55);
   endtask

   // Returns at the negedge where frame_done is seen; optionally pokes send_go
   // with a different frame while bytes 2 and 6 are outstanding.
   task automatic wait0(input bit ign, output bit got);
      int lastp;
      lastp = -1;
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         send_go0 = 1'b0;
         if (fd0) got = 1'b1;
         else if (ign && q0.size() != lastp && (q0.size() == 3 || q0.size() == 7)) begin
            lastp    = q0.size();
            cmd      = 8'h33;
            payload  = {5{8'h77}};
            send_go0 = 1'b1;
         end
      end
      chk("frame_done0_seen", got, 1);
   endtask

   task automatic run0(input int vi, input bit ign);
      int n0;
      bit got;
      n0 = nfd0;
      start0(vi);
      wait0(ign, got);
      @(posedge clk); #1;
      cmp($sformatf("frame%0d", vi), 0, vi);
      chk("one_frame_done", nfd0 - n0, 1);
      repeat (20) @(posedge clk);
      #1;
      chk("no_extra_send", q0.size(), NB);
      chk("no_extra_frame", nfd0 - n0, 1);
   endtask

   initial begin
      bit got;
      int n0;
      vec[0] = '{8'hA6, 40'h00_00_05_00_00, 72'h55_A5_A6_00_00_05_00_00_AB};
      vec[1] = '{8'hA7, 40'h00_00_00_00_00, 72'h55_A5_A7_00_00_00_00_00_A7};
      vec[2] = '{8'h11, 40'h04_03_02_01_00, 72'h55_A5_11_00_01_02_03_04_1B};
      vec[3] = '{8'hFF, 40'hFF_FF_FF_FF_FF, 72'h55_A5_FF_FF_FF_FF_FF_FF_FA};
      vec[4] = '{8'h3C, 40'h80_40_20_10_08, 72'h55_A5_3C_08_10_20_40_80_34};

      rst = 1'b1; send_go0 = 1'b0; send_go3 = 1'b0; cmd = 8'h00; payload = 40'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy0, 0);
      chk("rst_frame_done", fd0, 0);
      chk("rst_tx_send_go", sgo0, 0);
      chk("rst_tx_data", data0, 8'h00);
      chk("rst_busy3", busy3, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Table of plain frames.
      for (int vi = 0; vi < 5; vi++) run0(vi, 1'b0);

      // send_go while busy is ignored; cmd/payload changes do not leak in.
      run0(3, 1'b1);

      // Back-to-back: request in the frame_done cycle.
      n0 = nfd0;
      start0(0);
      wait0(1'b0, got);
      cmd      = vec[2].cmd;
      payload  = vec[2].payload;
      send_go0 = 1'b1;
      cmp("b2b_first", 0, 0);
      q0.delete();
      @(posedge clk); #1 send_go0 = 1'b0;
      chk("b2b_sgo", sgo0, 1);
      chk("b2b_hdr0", data0, 8'h55);
      chk("b2b_busy", busy0, 1);
      wait0(1'b0, got);
      @(posedge clk); #1;
      cmp("b2b_second", 0, 2);
      chk("b2b_frames", nfd0 - n0, 2);

      // Reset while waiting on byte 4.
      start0(1);
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (q0.size() == 5) got = 1'b1;
      end
      chk("reached_byte4", got, 1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      n0 = nfd0;
      #1;
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_sgo", sgo0, 0);
      chk("mid_rst_data", data0, 8'h00);
      chk("mid_rst_fd", fd0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("no_fd_after_rst", nfd0 - n0, 0);
      chk("idle_after_rst", busy0, 0);
      run0(4, 1'b0);

      // Inter-byte gap of 3 cycles.
      cmd     = vec[2].cmd;
      payload = vec[2].payload;
      q3.delete();
      n0 = nfd3;
      @(posedge clk); #1 send_go3 = 1'b1;
      @(posedge clk); #1 send_go3 = 1'b0;
      chk("gap_accept_sgo", sgo3, 1);
      got = 1'b0;
      for (int k = 0; k < 600 && !got; k++) begin
         @(negedge clk);
         if (fd3) got = 1'b1;
      end
      chk("frame_done3_seen", got, 1);
      @(posedge clk); #1;
      cmp("gapframe", 3, 2);
      repeat (20) @(posedge clk);
      #1;
      chk("gap_no_extra_send", q3.size(), NB);
      chk("gap_one_frame", nfd3 - n0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Command-frame transmitter for the UART control link: on a one-cycle request it serializes an 8-byte frame (header 0x55 0xA5, command byte, 5 payload bytes) into the byte-level UART transmitter, one byte per send/done handshake. It is the transmit-side counterpart of the command decoder's frame format, so frames it emits are accepted byte-for-byte by that decoder (e.g. cmd 0xA6 with K+1 in frame byte 5). It sits between control logic (or a loopback test harness) and the byte-serial `uart_byte_tx`.

## Interface
- `HDR0`, 8'h55, first header byte (frame byte 0)
- `HDR1`, 8'hA5, second header byte (frame byte 1)
- `GAP_CYCLES`, 0, idle Clk cycles inserted between a byte's `tx_done` and the next `tx_send_go` (0..255)

- `Clk`  in  1  system clock, all logic on rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `send_go`  in  1  one-cycle frame request; sampled only when `busy`=0
- `cmd`  in  8  command byte (frame byte 2), latched on accept
- `payload`  in  40  payload; `payload[8*i+7:8*i]` is frame byte 3+i (i=0..4), latched on accept
- `busy`  out  1  high from cycle after accept until frame completes
- `frame_done`  out  1  one-cycle pulse when last byte's `tx_done` has been seen
- `tx_data`  out  8  byte to byte transmitter; stable while a byte is outstanding
- `tx_send_go`  out  1  one-cycle pulse starting one byte transmission
- `tx_done`  in  1  one-cycle pulse from byte transmitter: current byte finished

## Operation
- States: IDLE, SEND, WAIT, GAP.
- IDLE: `busy`=0. `send_go`=1 → latch `cmd`/`payload` into frame registers, byte index ← 0, go SEND.
- SEND (1 cycle): `tx_send_go`=1, `tx_data`=frame byte[index]; go WAIT.
- WAIT: hold `tx_data`. On `tx_done`: if index = last → `frame_done`, go IDLE; else index+1, go GAP if `GAP_CYCLES`>0 (counter loaded with GAP_CYCLES), else SEND.
- GAP: count down; at zero go SEND.
- Frame bytes: 0=HDR0, 1=HDR1, 2=cmd, 3..7=payload bytes 0..4; last index = 7 (8 with checksum, see Configuration).
- `send_go` while `busy`=1: ignored, not queued; latched frame unchanged.
- `tx_done` in IDLE, SEND, or GAP: ignored.
- Changes on `cmd`/`payload` after accept have no effect on the frame in flight.

## Timing
- Reset values: `busy`=0, `frame_done`=0, `tx_send_go`=0, `tx_data`=8'h00; state IDLE, index 0, gap counter 0.
- Accept at cycle t → `busy`=1 and `tx_send_go`=1 with `tx_data`=HDR0 at t+1.
- `tx_done` at cycle u (non-last byte, GAP_CYCLES=0) → next `tx_send_go` at u+1; with GAP_CYCLES=G → at u+1+G.
- `tx_done` for last byte at u → at u+1: `frame_done`=1, `busy`=0, state IDLE; `send_go` at u+1 is accepted (back-to-back frames, next HDR0 send at u+2).
- `tx_done` coincident with the `tx_send_go` cycle is not a completion of that byte (state is SEND, ignored).
- `tx_data` updates only in the SEND cycle; holds its last value in IDLE.
- Reset asserted mid-frame: all outputs return to reset values immediately; frame abandoned; no `frame_done`. A byte already started in the byte transmitter is not cancelled by this block.

## Configuration
- `UART_FRAME_CHKSUM_EN` defined: a 9th byte (index 8) is appended = (cmd + payload bytes 0..4) mod 256, headers excluded; last index = 8.
- Not defined: 8-byte frame, last index = 7, no checksum logic.

## Test plan
- Reset, then `send_go` with cmd=8'hA6, payload=40'h00_00_05_00_00 (byte tx model, 10-cycle tx_done latency) → bytes 55 A5 A6 00 00 05 00 00 in order, `frame_done` once, `busy` low same cycle; with checksum also AB.
- cmd=8'hA7, payload=40'h0 → 55 A5 A7 00 00 00 00 00; checksum variant appends A7.
- GAP_CYCLES=3 → exactly 3 cycles between each `tx_done` and next `tx_send_go`; none after the last byte.
- `send_go` pulsed at bytes 2 and 6 of a frame with different cmd → ignored, original frame completes unchanged, no second frame.
- `send_go` in the `frame_done` cycle with cmd=8'h11 → second frame's HDR0 `tx_send_go` next cycle, bytes 55 A5 11 ...
- Assert `Reset` while waiting on byte 4 → outputs zero immediately, no `frame_done`; after release, new `send_go` produces a full frame from byte 0.
